fifo_write_ctrl: RTL and testbench
==================================

Name: fifo_write_ctrl

Overview:
Write-domain pointer and flag logic for the dual-clock gray-pointer FIFO. It pairs with the read-side logic.
- Accepts write requests and generates the storage write address and write enable.
- Publishes a gray write pointer for the read domain.
- Synchronises the read domain's gray pointer, then derives full, almost-full, free-slot count and an overflow flag.
- Sits between the router input port and the FIFO storage array.

Parameters:
PTR_SZ, 2, FIFO entry index width in bits (DEPTH = 2**PTR_SZ, legal PTR_SZ >= 1)
AFULL_THR, 1, wafull asserts when free slots <= AFULL_THR (0..DEPTH)

Ports:
clk  input  1  write-domain clock; all state is updated on its rising edge
rst  input  1  asynchronous, active-high reset
winc  input  1  write request for this cycle
raddr_gray  input  PTR_SZ+1  read pointer (gray) from the read domain, not yet synchronised
write_en  output  1  storage write strobe, = winc & !wfull (combinational)
waddr  output  PTR_SZ  storage write address, = wbin[PTR_SZ-1:0]
waddr_gray  output  PTR_SZ+1  registered gray write pointer, goes to the read domain
wfull  output  1  registered full flag
wafull  output  1  registered almost-full flag
wfree  output  PTR_SZ+1  registered free-slot count, 0..DEPTH
woverflow  output  1  sticky: a write was attempted while full

Behaviour:
- State: wbin (PTR_SZ+1 bits), wgray, two-flop synchroniser wq1/wq2 on raddr_gray, wfull, wafull, wfree, woverflow.
- Reset (async, takes effect immediately with no clock edge):
  - wbin, wgray, wq1, wq2, wfull, wafull, woverflow = 0; wfree = DEPTH.
  - write_en = 0 only while winc = 0 (it stays combinational).
- Synchroniser: wq1 <= raddr_gray; wq2 <= wq1 each edge.
- Accept rule: a write is accepted at an edge when winc & !wfull.
  - Storage captures data at that same edge, at address waddr.
  - wbin_next = wbin + accept, wrapping mod 2**(PTR_SZ+1); wgray_next = (wbin_next>>1)^wbin_next.
  - wbin <= wbin_next; wgray <= wgray_next; waddr_gray = wgray.
  - waddr therefore advances one cycle after the accepted write.
- Full: wfull <= (wgray_next == {~wq2[PTR_SZ:PTR_SZ-1], wq2[PTR_SZ-2:0]}). For PTR_SZ = 1 both bits are inverted.
- Free count:
  - rbin_s = gray2bin(wq2).
  - wfree <= DEPTH - ((wbin_next - rbin_s) mod 2**(PTR_SZ+1)).
  - wafull <= (that same next value <= AFULL_THR).
- Overflow: woverflow <= 1 when winc & wfull; cleared only by rst.
- Latency:
  - A read-side pointer change reaches wfull, wfree and wafull after exactly 3 clk edges (2 sync + 1 register).
  - Flags are pessimistic: full may persist up to 3 cycles after a read. A write into a truly full FIFO must never be accepted.
- Write of the last free slot: the write is accepted and wfull = 1 from the next edge.
- winc while full: no pointer change, write_en = 0, woverflow set.
- Wrap-around: wbin wraps from 2**(PTR_SZ+1)-1 to 0. The MSB toggle distinguishes full from empty, and no false full is allowed at wrap.
- Reset mid-operation: all pointers clear at once. The read side must be reset in the same window; its pointer restarts at 0.

Decomposition:
- Shared package/include fifo_pkg: bin2gray and gray2bin functions, and the DEPTH-from-PTR_SZ derivation. The read-side logic uses the same package.
- One sub-module: sync_2ff, a parameterised-width two-flop synchroniser with async active-high reset to 0. It is reused by the read side for rq2_waddr.

Test Plan:
All scenarios use PTR_SZ=2, DEPTH=4, AFULL_THR=1.
1. Reset: assert rst with clk stopped -> wfull=0, wafull=0, wfree=4, waddr=0, waddr_gray=000, woverflow=0, all immediately without a clock edge.
2. Fill from empty: raddr_gray=000, winc=1 for 4 edges ->
   - waddr 0,1,2,3; waddr_gray 001,011,010,110.
   - wfree 3,2,1,0; wafull=1 after edge 3; wfull=1 after edge 4.
3. Overflow: keep winc=1 while full for 2 cycles -> write_en=0, waddr_gray stays 110, woverflow=1 and still 1 after winc drops.
4. Full release: from full, drive raddr_gray=001 -> wfull=0 and wfree=1 exactly at the 3rd edge after the change; wafull stays 1.
5. Wrap: 12 writes with raddr_gray following waddr_gray after a 1-cycle lag -> wbin passes 7->0 (gray 100->000), wfull never asserts, waddr sequence repeats 0..3.
6. Async reset mid-fill: after 2 writes, pulse rst between edges -> waddr=0, waddr_gray=000, wfree=4 immediately; the next write goes to address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write- and read-side pointer logic of the
// dual-clock gray-pointer FIFO.
//   depth_of  - number of entries for a given index width
//   bin2gray  - binary to reflected gray code
//   gray2bin  - reflected gray code to binary
// The code conversions work on a 32-bit container; callers zero-extend a
// narrower pointer in and truncate the result, which is exact because zero
// upper bits contribute nothing to either conversion.
package fifo_pkg;

   function automatic int depth_of(input int ptr_sz);
      return 1 << ptr_sz;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Binary bit k is the XOR of all gray bits at or above k.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) b = b ^ (g >> i);
      return b;
   endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// fifo_write_ctrl_if: write-side handshake / pointer bundle.
//   winc        - write request (from the router port)
//   raddr_gray  - gray read pointer, still in the read clock domain
//   write_en    - storage write strobe
//   waddr       - storage write address
//   waddr_gray  - gray write pointer published to the read domain
//   wfull/wafull/wfree/woverflow - write-domain status
// master: the requester side; slave: fifo_write_ctrl.
interface fifo_write_ctrl_if #(
   parameter int PTR_SZ = 2
) ();
   logic              winc;
   logic [PTR_SZ:0]   raddr_gray;
   logic              write_en;
   logic [PTR_SZ-1:0] waddr;
   logic [PTR_SZ:0]   waddr_gray;
   logic              wfull;
   logic              wafull;
   logic [PTR_SZ:0]   wfree;
   logic              woverflow;

   modport master (
      output winc, raddr_gray,
      input  write_en, waddr, waddr_gray, wfull, wafull, wfree, woverflow
   );

   modport slave (
      input  winc, raddr_gray,
      output write_en, waddr, waddr_gray, wfull, wafull, wfree, woverflow
   );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a gray-coded multi-bit pointer.
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages to 0
//   d_i  - value from the source domain
//   q_o  - synchronised value, two destination edges late
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] q1_q, q2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1_q <= '0;
         q2_q <= '0;
      end else begin
         q1_q <= d_i;
         q2_q <= q1_q;
      end
   end

   assign q_o = q2_q;
endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-domain pointer and flag logic of the dual-clock
// gray-pointer FIFO.
//   clk  - write clock
//   rst  - asynchronous active-high reset
//   bus  - fifo_write_ctrl_if.slave (winc/raddr_gray in, strobe/address/
//          gray pointer/full/almost-full/free count/overflow out)
// Parameters: PTR_SZ (entry index width, DEPTH = 2**PTR_SZ) and AFULL_THR
// (almost-full asserts when free slots <= AFULL_THR). The interface must be
// instantiated with the same PTR_SZ.
module fifo_write_ctrl
   import fifo_pkg::*;
#(
   parameter int PTR_SZ    = 2,
   parameter int AFULL_THR = 1
) (
   input  logic            clk,
   input  logic            rst,
   fifo_write_ctrl_if.slave bus
);
   localparam int              PW        = PTR_SZ + 1;
   localparam int              DEPTH     = depth_of(PTR_SZ);
   localparam logic [PW-1:0]   DEPTH_W   = PW'(DEPTH);
   localparam logic [PW-1:0]   THR_W     = PW'(AFULL_THR);
   // Full when the write pointer equals the read pointer with its top two
   // gray bits inverted (for PTR_SZ = 1 that is both bits).
   localparam logic [PW-1:0]   FULL_MASK = PW'(3) << (PW - 2);

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic [PW-1:0] wfree_q, wfree_d;
   logic [PW-1:0] wq2, rbin_s;
   logic          wfull_q, wfull_d;
   logic          wafull_q, wafull_d;
   logic          wovf_q, wovf_d;
   logic          accept;

   sync_2ff #(.WIDTH(PW)) u_rptr_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus.raddr_gray),
      .q_o (wq2)
   );

   always_comb begin
      accept   = bus.winc & ~wfull_q;
      wbin_d   = wbin_q + PW'(accept);
      wgray_d  = PW'(bin2gray(32'(wbin_d)));
      rbin_s   = PW'(gray2bin(32'(wq2)));
      // Flags are computed from the next write pointer so a write into the
      // last free slot raises wfull on the same edge that accepts it.
      wfull_d  = (wgray_d == (wq2 ^ FULL_MASK));
      wfree_d  = DEPTH_W - (wbin_d - rbin_s);
      wafull_d = (wfree_d <= THR_W);
      wovf_d   = wovf_q | (bus.winc & wfull_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         wfree_q  <= DEPTH_W;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         wfree_q  <= wfree_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wovf_q   <= wovf_d;
      end
   end

   assign bus.write_en   = accept;
   assign bus.waddr      = wbin_q[PTR_SZ-1:0];
   assign bus.waddr_gray = wgray_q;
   assign bus.wfull      = wfull_q;
   assign bus.wafull     = wafull_q;
   assign bus.wfree      = wfree_q;
   assign bus.woverflow  = wovf_q;
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: directed bench for fifo_write_ctrl, PTR_SZ=2,
// AFULL_THR=1. Status vector layout used throughout:
//   {wfull, wafull, wfree[2:0], waddr[1:0], waddr_gray[2:0], woverflow}
module tb_fifo_write_ctrl;
   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst    = 1'b0;
   int   nvec   = 0;
   int   nerr   = 0;

   fifo_write_ctrl_if #(.PTR_SZ(2)) bus ();

   fifo_write_ctrl #(.PTR_SZ(2), .AFULL_THR(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 if (clk_en) clk = ~clk;

   logic [10:0] obs;
   assign obs = {bus.wfull, bus.wafull, bus.wfree, bus.waddr, bus.waddr_gray, bus.woverflow};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.winc       = 1'b0;
      bus.raddr_gray = 3'b000;
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (obs !== 11'b0_0_100_00_000_0) begin
         $display("FAIL reset_state got %b want %b", obs, 11'b0_0_100_00_000_0); nerr++;
      end
      nvec++;
      if (bus.write_en !== 1'b0) begin
         $display("FAIL reset_write_en_idle got %b want 0", bus.write_en); nerr++;
      end
      bus.winc = 1'b1;
      #1;
      nvec++;
      if (bus.write_en !== 1'b1) begin
         $display("FAIL reset_write_en_comb got %b want 1", bus.write_en); nerr++;
      end
      bus.winc = 1'b0;
      #1 rst = 1'b0;
      #1 clk_en = 1'b1;
   endtask

   task automatic test_fill;
      logic [10:0] exp_st [4];
      exp_st[0] = 11'b0_0_011_01_001_0;
      exp_st[1] = 11'b0_0_010_10_011_0;
      exp_st[2] = 11'b0_1_001_11_010_0;
      exp_st[3] = 11'b1_1_000_00_110_0;
      for (int k = 0; k < 4; k++) begin
         bus.winc = 1'b1;
         #1;
         nvec++;
         if ({bus.write_en, bus.waddr} !== {1'b1, 2'(k)}) begin
            $display("FAIL fill_addr[%0d] got %b want %b", k, {bus.write_en, bus.waddr}, {1'b1, 2'(k)}); nerr++;
         end
         tick();
         nvec++;
         if (obs !== exp_st[k]) begin
            $display("FAIL fill_state[%0d] got %b want %b", k, obs, exp_st[k]); nerr++;
         end
      end
   endtask

   task automatic test_overflow;
      bus.winc = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         nvec++;
         if (bus.write_en !== 1'b0) begin
            $display("FAIL ovf_write_en[%0d] got %b want 0", k, bus.write_en); nerr++;
         end
         tick();
         nvec++;
         if (obs !== 11'b1_1_000_00_110_1) begin
            $display("FAIL ovf_state[%0d] got %b want %b", k, obs, 11'b1_1_000_00_110_1); nerr++;
         end
      end
      bus.winc = 1'b0;
      tick();
      nvec++;
      if (obs !== 11'b1_1_000_00_110_1) begin
         $display("FAIL ovf_sticky got %b want %b", obs, 11'b1_1_000_00_110_1); nerr++;
      end
   endtask

   task automatic test_full_release;
      logic [10:0] exp;
      bus.raddr_gray = 3'b001;
      for (int e = 1; e <= 3; e++) begin
         tick();
         exp = (e < 3) ? 11'b1_1_000_00_110_1 : 11'b0_1_001_00_110_1;
         nvec++;
         if (obs !== exp) begin
            $display("FAIL release_edge%0d got %b want %b", e, obs, exp); nerr++;
         end
      end
   endtask

   task automatic test_wrap;
      logic [2:0] g [8];
      logic [2:0] exp_g;
      g[0] = 3'b000; g[1] = 3'b001; g[2] = 3'b011; g[3] = 3'b010;
      g[4] = 3'b110; g[5] = 3'b111; g[6] = 3'b101; g[7] = 3'b100;
      // Let the reader catch up completely first: free = 4.
      bus.raddr_gray = 3'b110;
      for (int k = 0; k < 3; k++) tick();
      nvec++;
      if (obs !== 11'b0_0_100_00_110_1) begin
         $display("FAIL wrap_start got %b want %b", obs, 11'b0_0_100_00_110_1); nerr++;
      end
      for (int i = 0; i < 12; i++) begin
         bus.raddr_gray = g[(4 + i) % 8];
         bus.winc       = 1'b1;
         #1;
         nvec++;
         if ({bus.write_en, bus.waddr, bus.wfull} !== {1'b1, 2'((4 + i) % 4), 1'b0}) begin
            $display("FAIL wrap_pre[%0d] got %b want %b", i, {bus.write_en, bus.waddr, bus.wfull},
                     {1'b1, 2'((4 + i) % 4), 1'b0}); nerr++;
         end
         tick();
         exp_g = g[(5 + i) % 8];
         nvec++;
         if ({bus.waddr_gray, bus.wfull} !== {exp_g, 1'b0}) begin
            $display("FAIL wrap_post[%0d] got %b want %b", i, {bus.waddr_gray, bus.wfull}, {exp_g, 1'b0}); nerr++;
         end
      end
      bus.winc = 1'b0;
   endtask

   task automatic test_reset_midfill;
      rst = 1'b1;
      bus.raddr_gray = 3'b000;
      #1 rst = 1'b0;
      bus.winc = 1'b1;
      tick();
      tick();
      bus.winc = 1'b0;
      nvec++;
      if (obs !== 11'b0_0_010_10_011_0) begin
         $display("FAIL midfill_two got %b want %b", obs, 11'b0_0_010_10_011_0); nerr++;
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (obs !== 11'b0_0_100_00_000_0) begin
         $display("FAIL midfill_reset got %b want %b", obs, 11'b0_0_100_00_000_0); nerr++;
      end
      rst = 1'b0;
      bus.winc = 1'b1;
      #1;
      nvec++;
      if ({bus.write_en, bus.waddr} !== 3'b1_00) begin
         $display("FAIL midfill_next_addr got %b want %b", {bus.write_en, bus.waddr}, 3'b1_00); nerr++;
      end
      tick();
      bus.winc = 1'b0;
      nvec++;
      if (obs !== 11'b0_0_011_01_001_0) begin
         $display("FAIL midfill_after got %b want %b", obs, 11'b0_0_011_01_001_0); nerr++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_release();
      test_wrap();
      test_reset_midfill();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
